// File: rtl/pe_mul_pkg.sv
// Shared definitions for the pe_mul arbiter slice.
// Holds the FSM state encoding and the default operand width and
// requester count. Other files pick these up with import pe_mul_pkg::*.
package pe_mul_pkg;

  localparam int DEF_BITWIDTH = 8;
  localparam int DEF_NREQ     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pe_mul_arbiter_shift_add_core.sv
// shift_add_core: serial unsigned shift-add multiplier datapath.
// Ports:
//   fast_clk  in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   latch operands, load cnt = BITWIDTH, clear accumulator
//   mcand_in  in   multiplicand to latch on start
//   mplr_in   in   multiplier to latch on start
//   done      out  high during the last shift-add cycle (cnt == 1)
//   product   out  low 2*BITWIDTH bits of the accumulator
// One multiplier bit is consumed per cycle while cnt is non-zero, so a
// full product takes exactly BITWIDTH cycles after start, whatever the
// operand values are.
module shift_add_core #(
  parameter int BITWIDTH = 8
) (
  input  logic                    fast_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BITWIDTH-1:0]     mcand_in,
  input  logic [BITWIDTH-1:0]     mplr_in,
  output logic                    done,
  output logic [2*BITWIDTH-1:0]   product
);

  localparam int CW = $clog2(BITWIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BITWIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  logic [BITWIDTH-1:0] mcand;
  logic [BITWIDTH-1:0] mplr;
  // One extra bit above the product keeps the carry of the upper-half add.
  logic [2*BITWIDTH:0] acc;
  logic [2*BITWIDTH:0] acc_add;
  logic [BITWIDTH:0]   upper_sum;
  logic [CW-1:0]       cnt;

  // Conditional add of the multiplicand into the accumulator upper half.
  always_comb begin
    upper_sum = acc[2*BITWIDTH:BITWIDTH] + {1'b0, mcand};
    if (mplr[0]) begin
      acc_add = {upper_sum, acc[BITWIDTH-1:0]};
    end else begin
      acc_add = acc;
    end
  end

  // Operand, accumulator and iteration-count registers.
  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      mcand <= mcand_in;
      mplr  <= mplr_in;
      acc   <= '0;
      cnt   <= CNT_LOAD;
    end else if (cnt != '0) begin
      acc   <= acc_add >> 1'b1;
      mplr  <= mplr >> 1'b1;
      cnt   <= cnt - CNT_ONE;
    end else begin
      acc   <= acc;
      mplr  <= mplr;
      cnt   <= cnt;
    end
  end

  assign done    = (cnt == CNT_ONE);
  assign product = acc[2*BITWIDTH-1:0];

endmodule

// File: rtl/pe_mul_arbiter.sv
// pe_mul_arbiter: NREQ requesters share one serial shift-add multiplier.
// Ports:
//   fast_clk   in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   req        in   per-requester request, held until its gnt bit pulses
//   din1_flat  in   multiplicands, requester i at [i*BITWIDTH +: BITWIDTH]
//   din2_flat  in   multipliers, same packing
//   gnt        out  one-hot pulse in the IDLE cycle whose closing edge
//                   latches that requester's operands
//   busy       out  high whenever the FSM is not IDLE
//   rsp_valid  out  product available on dout
//   rsp_ready  in   consumer accepts dout when high with rsp_valid
//   rsp_id     out  requester index owning dout
//   dout       out  unsigned product, 0 while rsp_valid is low
// Round-robin search starts one past the previous winner; after reset the
// pointer sits at NREQ-1 so requester 0 has top priority.
module pe_mul_arbiter
  import pe_mul_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int NREQ     = DEF_NREQ,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      fast_clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*BITWIDTH-1:0]  din1_flat,
  input  logic [NREQ*BITWIDTH-1:0]  din2_flat,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [2*BITWIDTH-1:0]     dout
);

  state_t                  state;
  state_t                  next_state;
  logic [IDW-1:0]          ptr;
  logic [IDW-1:0]          winner;
  logic [IDW-1:0]          cand_idx;
  int                      cand;
  logic                    found;
  logic                    start;
  logic [BITWIDTH-1:0]     sel_din1;
  logic [BITWIDTH-1:0]     sel_din2;
  logic                    core_done;
  logic [2*BITWIDTH-1:0]   product;

  // Round-robin search: first set req bit at (ptr + 1 + i) mod NREQ.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand     = (int'(ptr) + 32'sd1 + i) % NREQ;
      cand_idx = IDW'(cand);
      if (!found && req[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end else begin
        found  = found;
        winner = winner;
      end
    end
  end

  // Winner operand select; other slots never reach the datapath.
  always_comb begin
    sel_din1 = din1_flat[int'(winner)*BITWIDTH +: BITWIDTH];
    sel_din2 = din2_flat[int'(winner)*BITWIDTH +: BITWIDTH];
  end

  // A grant needs reset released so gnt stays 0 throughout reset.
  assign start = rst && (state == IDLE) && found;

  shift_add_core #(
    .BITWIDTH (BITWIDTH)
  ) u_core (
    .fast_clk (fast_clk),
    .rst      (rst),
    .start    (start),
    .mcand_in (sel_din1),
    .mplr_in  (sel_din2),
    .done     (core_done),
    .product  (product)
  );

  // State register, round-robin pointer and response owner.
  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= IDW'(NREQ - 1);
      rsp_id <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        ptr    <= winner;
        rsp_id <= winner;
      end else begin
        ptr    <= ptr;
        rsp_id <= rsp_id;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state = state;
    gnt        = '0;
    busy       = (state != IDLE);
    rsp_valid  = (state == DONE);
    dout       = '0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state  = RUN;
          gnt[winner] = 1'b1;
        end else begin
          next_state  = IDLE;
        end
      end
      RUN: begin
        if (core_done) begin
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        dout = product;
        if (rsp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pe_mul_arbiter.sv
// Self-checking bench for pe_mul_arbiter (BITWIDTH = 8, NREQ = 4).
// Expected grants come from a round-robin model over the request mask,
// expected products from plain multiplication of the granted operands.
module tb_pe_mul_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic             fast_clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din1_flat;
  logic [N*W-1:0]   din2_flat;
  logic [N-1:0]     gnt;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [2*W-1:0]   dout;

  int checks   = 0;
  int fails    = 0;
  int last_win = N - 1;

  always #5 fast_clk = ~fast_clk;

  pe_mul_arbiter #(
    .BITWIDTH (W),
    .NREQ     (N)
  ) dut (
    .fast_clk  (fast_clk),
    .rst       (rst),
    .req       (req),
    .din1_flat (din1_flat),
    .din2_flat (din2_flat),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .dout      (dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample/drive point: 1 time unit after the falling edge.
  task automatic tick();
    @(negedge fast_clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (last_win + 1 + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_ops(input int s, input logic [W-1:0] a, input logic [W-1:0] b);
    din1_flat[s*W +: W] = a;
    din2_flat[s*W +: W] = b;
  endtask

  // One full transaction: grant, RUN latency, optional stall, handshake.
  task automatic run_op(input int stall, input bit drop);
    int             w;
    int             lat;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_p;
    logic [N-1:0]   oh;
    w  = pick(req);
    oh = '0;
    oh[w] = 1'b1;
    a  = din1_flat[w*W +: W];
    b  = din2_flat[w*W +: W];
    exp_p = 16'(a) * 16'(b);
    rsp_ready = (stall == 0);
    #1;
    check("grant", gnt, oh);
    check("idle_busy", busy, 0);
    last_win = w;
    tick();
    if (drop) req[w] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      check("run_busy", busy, 1);
      check("run_gnt", gnt, 0);
      check("run_dout", dout, 0);
      tick();
      lat++;
    end
    check("latency", lat, W + 1);
    check("dout", dout, exp_p);
    check("rsp_id", rsp_id, w);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", rsp_valid, 1);
      check("stall_dout", dout, exp_p);
      check("stall_id", rsp_id, w);
      check("stall_gnt", gnt, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("post_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
    check("post_dout", dout, 0);
  endtask

  initial begin
    logic [N-1:0] oh;
    rst       = 1'b0;
    req       = 4'b1111;
    din1_flat = 32'h0;
    din2_flat = 32'h0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_dout", dout, 0);

    // All four requesting continuously: grants 0,1,2,3,0.
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din1_flat = $urandom();
      din2_flat = $urandom();
      req = 4'b1111;
      run_op(0, 1'b0);
    end

    // Single requester 0: 13 * 11.
    req = 4'b0001;
    set_ops(0, 8'd13, 8'd11);
    run_op(0, 1'b1);

    // Max operands on requester 2; other slots unknown.
    din1_flat = 'x;
    din2_flat = 'x;
    req = 4'b0100;
    set_ops(2, 8'hFF, 8'hFF);
    run_op(0, 1'b1);

    // 20-cycle stall in DONE with others pending, then drain them.
    din1_flat = $urandom();
    din2_flat = $urandom();
    req = 4'b1011;
    run_op(20, 1'b1);
    run_op(0, 1'b1);
    run_op(0, 1'b1);

    // Zero multiplicand still takes full latency.
    req = 4'b0010;
    set_ops(1, 8'd0, 8'hA5);
    run_op(0, 1'b1);

    // Randomized masks, operands and stalls.
    for (int k = 0; k < 8; k++) begin
      din1_flat = $urandom();
      din2_flat = $urandom();
      req = 4'($urandom_range(1, 15));
      run_op(int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset in RUN cycle 4 aborts the operation.
    din1_flat = $urandom();
    din2_flat = $urandom();
    req = 4'b0010;
    oh = '0;
    oh[pick(req)] = 1'b1;
    #1;
    check("abort_grant", gnt, oh);
    tick();
    req = 4'b0000;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("abort_gnt", gnt, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", rsp_valid, 0);
    check("abort_id", rsp_id, 0);
    check("abort_dout", dout, 0);
    last_win = N - 1;
    tick();
    tick();
    check("abort_hold_valid", rsp_valid, 0);
    rst = 1'b1;
    req = 4'b1000;
    set_ops(3, 8'($urandom()), 8'($urandom()));
    run_op(1, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pe_mul_arbiter.md
PE_MUL_ARBITER -- requirements
Module: pe_mul_arbiter

Interface
REQ-001 Parameter BITWIDTH, default 8: operand width; product is 2*BITWIDTH bits.
REQ-002 Parameter NREQ, default 4: number of requesters; IDW = clog2(NREQ), min 1.
REQ-003 fast_clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req  in  NREQ  per-requester request; held by requester until its gnt bit pulses.
REQ-006 din1_flat  in  NREQ*BITWIDTH  multiplicands; requester i at bits [i*BITWIDTH +: BITWIDTH].
REQ-007 din2_flat  in  NREQ*BITWIDTH  multipliers; same packing as din1_flat.
REQ-008 gnt  out  NREQ  one-hot, one-cycle pulse; operands of that requester latched on the same edge.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 rsp_valid  out  1  product available on dout.
REQ-011 rsp_ready  in  1  consumer accepts the product when high together with rsp_valid.
REQ-012 rsp_id  out  IDW  index of the requester that owns dout.
REQ-013 dout  out  2*BITWIDTH  unsigned product din1*din2; 0 when rsp_valid low.

Function
REQ-014 FSM states: IDLE, RUN, DONE; one state per cycle, no other states.
REQ-015 IDLE: with any req bit set, select the winner round-robin, starting at (last winner + 1) mod NREQ, with wrap from NREQ-1 to 0.
REQ-016 On that edge: latch the winner's operands, pulse gnt[winner], load cnt = BITWIDTH, clear the accumulator, and enter RUN.
REQ-017 RUN: each cycle, if multiplier LSB = 1, add the multiplicand into the accumulator upper half.
REQ-018 RUN: each cycle, then shift the accumulator and the multiplier right by 1.
REQ-019 Accumulator is 2*BITWIDTH+1 bits so the carry is never lost.
REQ-020 cnt decrements once per RUN cycle; at cnt = 1, the next state is DONE.
REQ-021 Latency: rsp_valid rises exactly BITWIDTH+1 cycles after the gnt pulse (9 cycles for BITWIDTH = 8).
REQ-022 DONE: rsp_valid = 1; dout and rsp_id are stable until the handshake.
REQ-023 DONE: when rsp_valid && rsp_ready, return to IDLE on that edge.
REQ-024 rsp_ready low in DONE stalls indefinitely; no new grant is issued during a stall.
REQ-025 The earliest next grant is the edge after the first IDLE cycle, so there are no back-to-back grants without an IDLE cycle between them.
REQ-026 req changes during RUN/DONE are ignored; a req deasserted before its grant is never served.
REQ-027 Operand 0 on either input gives dout = 0 after full latency; there is no early termination.
REQ-028 Any req bit set with din values X in non-winning slots shall not affect the result.

Reset
REQ-029 While rst = 0: state = IDLE, gnt = 0, busy = 0, rsp_valid = 0, rsp_id = 0, dout = 0, cnt = 0, accumulator = 0.
REQ-030 While rst = 0: round-robin pointer set so requester 0 has highest priority.
REQ-031 Reset asserted mid-RUN or mid-DONE aborts the operation; the in-flight result is discarded and no rsp_valid is produced.
REQ-032 First grant after reset release no earlier than the first rising edge with rst = 1.

Structure
REQ-033 Shared package pe_mul_pkg holds the FSM state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and default BITWIDTH/NREQ constants.
REQ-034 Shift-add datapath (operand registers, accumulator, cnt) in sub-module shift_add_core with start/done/product ports.
REQ-035 FSM, round-robin selection and response handshake stay in pe_mul_arbiter.

Verification
REQ-036 Single req[0], din1 = 8'd13, din2 = 8'd11, rsp_ready = 1 -> gnt = 4'b0001; 9 cycles later rsp_valid = 1, dout = 16'd143, rsp_id = 0.
REQ-037 Max operands 8'hFF x 8'hFF on req[2] -> dout = 16'hFE01, rsp_id = 2.
REQ-038 req = 4'b1111 held continuously -> grant order 0, 1, 2, 3, 0; pointer wraps.
REQ-039 rsp_ready low for 20 cycles in DONE -> rsp_valid, dout and rsp_id stay stable and gnt stays 0.
REQ-040 Handshake completes one cycle later -> IDLE, then next grant.
REQ-041 rst pulsed low at RUN cycle 4 -> all outputs 0 immediately, no rsp_valid; the next req[3] is granted cleanly with a correct product.
REQ-042 din1 = 0, din2 = 8'hA5 -> dout = 0 after exactly 9 cycles.
